// File: rtl/sig_debounce_filter_pkg.sv
// Shared types and constants for the debounce filter and related input-conditioning blocks.
package sig_debounce_filter_pkg;

    // Filter FSM states; code 2'd3 is unused and recovers to ST_INIT.
    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_STABLE  = 2'd1,
        ST_QUALIFY = 2'd2
    } state_t;

    localparam int unsigned GLITCH_CNT_W = 8;
    localparam logic [GLITCH_CNT_W-1:0] GLITCH_SAT = 8'hFF;

endpackage

// File: rtl/sig_sync_chain.sv
// Multi-flop synchronizer bringing an asynchronous pin into the iClk domain.
// Ports:
//   iClk      clock
//   iRst_n    synchronous active-low reset, loads RESET_VALUE into every stage
//   async_in  raw asynchronous input
//   sync_out  synchronized level (last stage of the chain)
module sig_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic async_in,
    output logic sync_out
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
        $error("sig_sync_chain: SYNC_STAGES must be in 2..4");
    end

    logic [SYNC_STAGES-1:0] chain_q;

    // Shift register: stage 0 captures the pin, the last stage feeds the consumer.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            chain_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sig_debounce_filter.sv
// Synchronizes and debounces a board-level status pin, presenting a clean
// level for the downstream edge detector.
// Ports:
//   iClk           clock
//   iRst_n         synchronous active-low reset
//   iClear         synchronous re-qualify request (keeps output_sig)
//   input_sig      raw asynchronous pin
//   output_sig     debounced level
//   output_valid   high once a level has been qualified
//   output_change  one-cycle pulse on each accepted toggle of output_sig
//   glitch_cnt     saturating count of rejected transitions
module sig_debounce_filter
    import sig_debounce_filter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned DEBOUNCE_CNT = 16,
    parameter logic        RESET_VALUE  = 1'b0
) (
    input  logic                    iClk,
    input  logic                    iRst_n,
    input  logic                    iClear,
    input  logic                    input_sig,
    output logic                    output_sig,
    output logic                    output_valid,
    output logic                    output_change,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DEBOUNCE_CNT < 2) begin : g_bad_cnt
        $error("sig_debounce_filter: DEBOUNCE_CNT must be >= 2");
    end

    logic sync_s;

    sig_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VALUE (RESET_VALUE)
    ) u_sync (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .async_in (input_sig),
        .sync_out (sync_s)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cand_q, cand_d;
    logic                    out_d, valid_d, change_d;
    logic [GLITCH_CNT_W-1:0] glitch_d;

    // State and output registers.
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            state_q       <= ST_INIT;
            cnt_q         <= '0;
            cand_q        <= RESET_VALUE;
            output_sig    <= RESET_VALUE;
            output_valid  <= 1'b0;
            output_change <= 1'b0;
            glitch_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            output_sig    <= out_d;
            output_valid  <= valid_d;
            output_change <= change_d;
            glitch_cnt    <= glitch_d;
        end
    end

    // Next-state and output logic; iClear overrides any FSM activity.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        out_d    = output_sig;
        valid_d  = output_valid;
        change_d = 1'b0;
        glitch_d = glitch_cnt;

        if (iClear) begin
            state_d  = ST_INIT;
            cnt_d    = '0;
            cand_d   = output_sig;
            valid_d  = 1'b0;
            glitch_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    valid_d = 1'b0;
                    if (sync_s != cand_q) begin
                        // New candidate level; this sample is the first of the run.
                        cand_d = sync_s;
                        cnt_d  = CNT_ONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Initial lock is silent: no output_change pulse.
                        out_d   = cand_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (sync_s != output_sig) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (sync_s == output_sig) begin
                        if (glitch_cnt != GLITCH_SAT) begin
                            glitch_d = glitch_cnt + GLITCH_CNT_W'(1);
                        end
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else if (cnt_q == CNT_LAST) begin
                        out_d    = sync_s;
                        change_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

endmodule
